// File: rtl/core_arf_sb.sv
// Architectural register file with a per-register busy scoreboard, optional hardwired r0,
// and optional same-cycle write-to-read bypass.
module core_arf_sb #(
    parameter int XLEN     = 16,
    parameter int NREGS    = 16,
    parameter int R_PORTS  = 3,
    parameter int W_PORTS  = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [R_PORTS*AW-1:0]   rd_addr_i,
    output logic [R_PORTS*XLEN-1:0] rd_data_o,
    output logic [R_PORTS-1:0]      rd_busy_o,
    input  logic [W_PORTS-1:0]      wr_en_i,
    input  logic [W_PORTS*AW-1:0]   wr_addr_i,
    input  logic [W_PORTS*XLEN-1:0] wr_data_i,
    input  logic                    rsv_en_i,
    input  logic [AW-1:0]           rsv_addr_i,
    output logic                    rsv_ready_o,
    output logic [NREGS-1:0]        busy_o,
    output logic                    wr_conflict_o
);

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   addr_t;

    word_t            mem_q [NREGS];
    word_t            mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             wr_conflict_q, wr_conflict_d;

    addr_t            rd_addr [R_PORTS];
    addr_t            wr_addr [W_PORTS];
    word_t            wr_data [W_PORTS];
    logic [NREGS-1:0] wr_hit;

    for (genvar i = 0; i < R_PORTS; i++) begin : g_rd
        assign rd_addr[i] = rd_addr_i[i*AW +: AW];
    end

    for (genvar j = 0; j < W_PORTS; j++) begin : g_wr
        assign wr_addr[j] = wr_addr_i[j*AW +: AW];
        assign wr_data[j] = wr_data_i[j*XLEN +: XLEN];
    end

    // Write-effective: in range, and not the hardwired zero register.
    function automatic logic wr_effective(input addr_t a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < W_PORTS; j++) begin
            if (wr_en_i[j] && wr_effective(wr_addr[j])) begin
                wr_hit[wr_addr[j]] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < R_PORTS; i++) begin
            if (wr_effective(rd_addr[i])) begin
                rd_data_o[i*XLEN +: XLEN] = mem_q[rd_addr[i]];
                if (BYPASS != 0) begin
                    // Ascending scan: the highest-index matching port wins.
                    for (int j = 0; j < W_PORTS; j++) begin
                        if (wr_en_i[j] && (wr_addr[j] == rd_addr[i])) begin
                            rd_data_o[i*XLEN +: XLEN] = wr_data[j];
                        end
                    end
                end
                rd_busy_o[i] = busy_q[rd_addr[i]] & ~((BYPASS != 0) & wr_hit[rd_addr[i]]);
            end
        end
    end

    always_comb begin
        rsv_ready_o = 1'b0;
        if (rsv_en_i) begin
            if ((ZERO_REG != 0) && (rsv_addr_i == '0)) begin
                rsv_ready_o = 1'b1;
            end else if (int'(rsv_addr_i) < NREGS) begin
                rsv_ready_o = ~busy_q[rsv_addr_i] | wr_hit[rsv_addr_i];
            end
        end
    end

    always_comb begin
        mem_d         = mem_q;
        busy_d        = busy_q & ~wr_hit;
        wr_conflict_d = 1'b0;
        for (int j = 0; j < W_PORTS; j++) begin
            if (wr_en_i[j] && wr_effective(wr_addr[j])) begin
                mem_d[wr_addr[j]] = wr_data[j];
            end
        end
        // A reservation overrides a same-cycle clear: the new producer is still in flight.
        if (rsv_ready_o && wr_effective(rsv_addr_i)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        for (int j = 0; j < W_PORTS; j++) begin
            for (int k = j + 1; k < W_PORTS; k++) begin
                if (wr_en_i[j] && wr_en_i[k] && (wr_addr[j] == wr_addr[k]) &&
                    wr_effective(wr_addr[j])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the register array is reset because architectural state must read 0 after reset.
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign busy_o        = busy_q;
    assign wr_conflict_o = wr_conflict_q;

endmodule
